// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared defaults, lane-result type and the per-lane add rule.
package half_adder_pkg;
    localparam int unsigned HA_WIDTH = 1;
    localparam int unsigned HA_CNT_W = 8;

    typedef struct packed {
        logic sum;
        logic c_out;
    } lane_res_t;

    function automatic lane_res_t add_bits(input logic a, input logic b);
        lane_res_t r;
        r.sum   = a ^ b;
        r.c_out = a & b;
        return r;
    endfunction
endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: one 1-bit half-adder lane.
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic      a,
    input  logic      b,
    output lane_res_t res
);
    assign res = add_bits(a, b);
endmodule

// File: rtl/half_adder.sv
// half_adder: WIDTH independent half-adder lanes with combinational outputs,
// a registered copy and a saturating count of accepted carry cycles.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_WIDTH,
    parameter int unsigned CNT_W = HA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] c_out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    lane_res_t        w_res [WIDTH];
    logic [WIDTH-1:0] r_sum_q;
    logic [WIDTH-1:0] r_c_out_q;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_carry_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .res (w_res[i])
        );
        assign sum[i]   = w_res[i].sum;
        assign c_out[i] = w_res[i].c_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q     <= '0;
            r_c_out_q   <= '0;
            r_out_valid <= 1'b0;
            r_carry_cnt <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum_q   <= sum;
                r_c_out_q <= c_out;
                // Counter sticks at its maximum instead of wrapping.
                if (|c_out && r_carry_cnt != CNT_MAX)
                    r_carry_cnt <= r_carry_cnt + 1'b1;
            end
        end
    end

    assign sum_q     = r_sum_q;
    assign c_out_q   = r_c_out_q;
    assign out_valid = r_out_valid;
    assign carry_cnt = r_carry_cnt;
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scenario tasks against an arithmetic reference model, on three parameterisations.
module tb_half_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a1, b1, v1, s1, c1, sq1, cq1, ov1;
    logic [7:0] cnt1;
    logic [3:0] a4, b4, s4, c4, sq4, cq4;
    logic       v4, ov4;
    logic [7:0] cnt4;
    logic       as, bs, vs, ss, cs, sqs, cqs, ovs;
    logic [1:0] cnts;

    int errors = 0;
    int checks = 0;
    int exp_cnt1, exp_cnt4, exp_cnts;
    logic [3:0] exp_sq4, exp_cq4;
    logic       exp_ov4;

    half_adder d1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .sum(s1), .c_out(c1),
                   .sum_q(sq1), .c_out_q(cq1), .out_valid(ov1), .carry_cnt(cnt1));
    half_adder #(.WIDTH(4), .CNT_W(8)) d4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
                   .sum(s4), .c_out(c4), .sum_q(sq4), .c_out_q(cq4), .out_valid(ov4), .carry_cnt(cnt4));
    half_adder #(.WIDTH(1), .CNT_W(2)) ds (.clk(clk), .rst_n(rst_n), .a(as), .b(bs), .in_valid(vs),
                   .sum(ss), .c_out(cs), .sum_q(sqs), .c_out_q(cqs), .out_valid(ovs), .carry_cnt(cnts));

    // Reference: each lane's arithmetic total is 0, 1 or 2; sum is "total is odd", carry is "total is two".
    function automatic logic [3:0] ref_sum(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
        return r;
    endfunction

    function automatic logic [3:0] ref_carry(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (int'(x[i]) + int'(y[i])) >= 2;
        return r;
    endfunction

    function automatic int sat_inc(input int cnt, input int bits);
        return (cnt + 1 > (1 << bits) - 1) ? (1 << bits) - 1 : cnt + 1;
    endfunction

    task automatic test_comb();
        logic [1:0] pats [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        for (int k = 0; k < 4; k++) begin
            logic [3:0] es, ec;
            {a1, b1} = pats[k];
            #1;
            es = ref_sum({3'b0, a1}, {3'b0, b1});
            ec = ref_carry({3'b0, a1}, {3'b0, b1});
            checks++; if ({3'b0, s1} !== es) begin errors++; $display("FAIL comb_sum[%0d]: got %0b expected %0b", k, s1, es[0]); end
            checks++; if ({3'b0, c1} !== ec) begin errors++; $display("FAIL comb_cout[%0d]: got %0b expected %0b", k, c1, ec[0]); end
            #9;
        end
    endtask

    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        #1;
        checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL rst_sum: got %0b expected 0", s1); end
        checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL rst_cout: got %0b expected 1", c1); end
        checks++; if ({sq1, cq1, ov1} !== 3'b000) begin errors++; $display("FAIL rst_regs: got %0b expected 000", {sq1, cq1, ov1}); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", cnt1); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        exp_cnt1 = sat_inc(0, 8);
        checks++; if ({sq1, cq1, ov1} !== 3'b011) begin errors++; $display("FAIL first_edge_regs: got %0b expected 011", {sq1, cq1, ov1}); end
        checks++; if (int'(cnt1) != exp_cnt1) begin errors++; $display("FAIL first_edge_cnt: got %0d expected %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_hold();
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        @(posedge clk) #1;
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
        @(posedge clk) #1;
        checks++; if (sq1 !== 1'b1) begin errors++; $display("FAIL hold_sum_q: got %0b expected 1", sq1); end
        checks++; if (cq1 !== 1'b0) begin errors++; $display("FAIL hold_cout_q: got %0b expected 0", cq1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL hold_out_valid: got %0b expected 0", ov1); end
        checks++; if (int'(cnt1) != exp_cnt1) begin errors++; $display("FAIL hold_cnt: got %0d expected %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_wide();
        a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
        #1;
        checks++; if (s4 !== ref_sum(a4, b4)) begin errors++; $display("FAIL wide_sum: got %b expected %b", s4, ref_sum(a4, b4)); end
        checks++; if (c4 !== ref_carry(a4, b4)) begin errors++; $display("FAIL wide_cout: got %b expected %b", c4, ref_carry(a4, b4)); end
        exp_sq4 = ref_sum(a4, b4); exp_cq4 = ref_carry(a4, b4);
        exp_cnt4 = exp_cnt4 + 1;
        @(posedge clk) #1;
        v4 = 1'b0;
        checks++; if ({sq4, cq4} !== {exp_sq4, exp_cq4}) begin errors++; $display("FAIL wide_regs: got %b expected %b", {sq4, cq4}, {exp_sq4, exp_cq4}); end
        checks++; if (int'(cnt4) != exp_cnt4) begin errors++; $display("FAIL wide_cnt: got %0d expected %0d", cnt4, exp_cnt4); end
        exp_ov4 = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); v4 = $urandom_range(0, 3) != 0;
            #1;
            checks++; if ({s4, c4} !== {ref_sum(a4, b4), ref_carry(a4, b4)}) begin errors++; $display("FAIL rand_comb[%0d]: got %b expected %b", k, {s4, c4}, {ref_sum(a4, b4), ref_carry(a4, b4)}); end
            if (v4) begin
                exp_sq4 = ref_sum(a4, b4); exp_cq4 = ref_carry(a4, b4);
                if (exp_cq4 != 0) exp_cnt4 = sat_inc(exp_cnt4, 8);
            end
            exp_ov4 = v4;
            @(posedge clk) #1;
            checks++; if ({sq4, cq4, ov4} !== {exp_sq4, exp_cq4, exp_ov4}) begin errors++; $display("FAIL rand_regs[%0d]: got %b expected %b", k, {sq4, cq4, ov4}, {exp_sq4, exp_cq4, exp_ov4}); end
            checks++; if (int'(cnt4) != exp_cnt4) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", k, cnt4, exp_cnt4); end
        end
        v4 = 1'b0;
    endtask

    task automatic test_saturation();
        as = 1'b1; bs = 1'b1; vs = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk) #1;
            exp_cnts = sat_inc(exp_cnts, 2);
            checks++; if (int'(cnts) != exp_cnts) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, cnts, exp_cnts); end
        end
        vs = 1'b0;
    endtask

    task automatic test_async_reset();
        a4 = 4'b1111; b4 = 4'b0111; v4 = 1'b1; vs = 1'b1;
        @(posedge clk) #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({sq4, cq4, ov4, cnt4} !== 17'd0) begin errors++; $display("FAIL async_rst_wide: got %h expected 0", {sq4, cq4, ov4, cnt4}); end
        checks++; if ({sqs, cqs, ovs, cnts} !== 5'd0) begin errors++; $display("FAIL async_rst_sat: got %h expected 0", {sqs, cqs, ovs, cnts}); end
        checks++; if ({s4, c4} !== {ref_sum(a4, b4), ref_carry(a4, b4)}) begin errors++; $display("FAIL async_rst_comb: got %b expected %b", {s4, c4}, {ref_sum(a4, b4), ref_carry(a4, b4)}); end
        v4 = 1'b0; vs = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a1 = 0; b1 = 0; v1 = 0; a4 = 0; b4 = 0; v4 = 0; as = 0; bs = 0; vs = 0;
        exp_cnt1 = 0; exp_cnt4 = 0; exp_cnts = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_comb();
        test_reset();
        test_hold();
        test_wide();
        test_random();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
